layers_mux_ctrl: RTL and testbench

Per-pixel layer arbiter and frame-synchronous controller for the VGA pixel path. It sits between the drawing blocks (four object layers plus the background/border drawer) and the VGA output stage. Each clock it picks one colour by fixed priority, masking transparent pixels and disabled layers, and registers the result. Per frame it also detects overlaps between layers and publishes them as flags for game logic, along with a frame counter.

---
 rtl/layers_mux_ctrl.sv | 139 +++++++++++++
 tb/tb_layers_mux_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layers_mux_ctrl.sv
// -----------------------------------------------------------------------------
// layers_mux_ctrl
// Per-pixel layer arbiter and frame-synchronous controller for the VGA path.
// Each clock it picks the colour of the highest-priority visible, enabled,
// non-transparent layer (layer 0 wins). If no layer qualifies it picks the
// background colour. Off-screen pixels are black. The chosen colour is
// registered.
// Per frame it ORs every collision participant into an accumulator. The
// accumulator is published as collisionFlags on startOfFrame, and
// frameCount is incremented at the same time.
//
// Ports
//   clk            pixel clock
//   resetN         asynchronous active-low reset
//   startOfFrame   one-cycle pulse on the first pixel of a frame
//   pixelX/pixelY  current pixel coordinates (11 bits each)
//   layerDrawReq   per-layer draw request, bit 0 = highest priority
//   layerRGB       layer i colour in [8i+7:8i], RRRGGGBB
//   BG_RGB         background colour
//   bordersDrawReq background drawer is painting a border/bracket pixel
//   enableMaskIn   requested layer enable mask
//   enableMaskWr   write strobe for enableMaskIn
//   RGBout         registered pixel colour
//   collisionPulse one-cycle pulse on the first collision of a frame
//   collisionFlags sticky collision flags of the previous frame
//                  (bit i = layer i, bit 4 = borders)
//   frameCount     completed frames, wraps at 8 bits
// -----------------------------------------------------------------------------
module layers_mux_ctrl #(
  parameter logic [7:0] TRANSPARENT_ENCODING = 8'hFF,
  parameter int         H_VISIBLE            = 640,
  parameter int         V_VISIBLE            = 480
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [3:0]  layerDrawReq,
  input  logic [31:0] layerRGB,
  input  logic [7:0]  BG_RGB,
  input  logic        bordersDrawReq,
  input  logic [3:0]  enableMaskIn,
  input  logic        enableMaskWr,
  output logic [7:0]  RGBout,
  output logic        collisionPulse,
  output logic [4:0]  collisionFlags,
  output logic [7:0]  frameCount
);

  logic [3:0] r_mask_pend;
  logic [3:0] r_mask_act;
  logic [4:0] r_acc;
  logic       r_seen;

  logic       w_visible;
  logic [3:0] w_mask_eff;
  logic [3:0] w_active;
  logic [4:0] w_part;
  logic [2:0] w_cnt;
  logic       w_coll;
  logic [7:0] w_rgb;
  logic       w_seen_eff;
  logic [4:0] w_acc_base;

  assign w_visible = (pixelX < 11'(H_VISIBLE)) && (pixelY < 11'(V_VISIBLE));

  // The startOfFrame pixel already belongs to the new frame, so it must see
  // the mask that becomes active on this edge. That is either the pending
  // value or a write landing on the same cycle.
  assign w_mask_eff = startOfFrame ? (enableMaskWr ? enableMaskIn : r_mask_pend)
                                   : r_mask_act;

  always_comb begin
    w_active = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w_active[i] = layerDrawReq[i] && w_mask_eff[i] && w_visible &&
                    (layerRGB[8*i +: 8] != TRANSPARENT_ENCODING);
    end
  end

  assign w_part = {bordersDrawReq && w_visible, w_active};

  always_comb begin
    w_cnt = 3'd0;
    for (int i = 0; i < 5; i++) begin
      w_cnt = w_cnt + 3'(w_part[i]);
    end
  end

  assign w_coll = (w_cnt >= 3'd2);

  // Scan from lowest priority up so the lowest-index active layer wins.
  always_comb begin
    w_rgb = BG_RGB;
    for (int i = 3; i >= 0; i--) begin
      if (w_active[i]) w_rgb = layerRGB[8*i +: 8];
    end
    if (!w_visible) w_rgb = 8'h00;
  end

  // On startOfFrame the frame state is cleared first. A collision on that
  // same pixel then counts toward the new frame.
  assign w_seen_eff = startOfFrame ? 1'b0 : r_seen;
  assign w_acc_base = startOfFrame ? 5'b00000 : r_acc;

  // Output stage: colour and collision pulse, one cycle after the inputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      RGBout         <= 8'h00;
      collisionPulse <= 1'b0;
    end else begin
      RGBout         <= w_rgb;
      collisionPulse <= w_coll && !w_seen_eff;
    end
  end

  // Frame control: masks, accumulator and published per-frame state
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_mask_pend    <= 4'b1111;
      r_mask_act     <= 4'b1111;
      r_acc          <= 5'b00000;
      r_seen         <= 1'b0;
      collisionFlags <= 5'b00000;
      frameCount     <= 8'h00;
    end else begin
      if (enableMaskWr) r_mask_pend <= enableMaskIn;
      if (startOfFrame) begin
        r_mask_act     <= w_mask_eff;
        collisionFlags <= r_acc;
        frameCount     <= frameCount + 8'd1;
      end
      r_acc  <= w_coll ? (w_acc_base | w_part) : w_acc_base;
      r_seen <= w_seen_eff || w_coll;
    end
  end

endmodule

// File: tb/tb_layers_mux_ctrl.sv
module tb_layers_mux_ctrl;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic [3:0]  layerDrawReq;
  logic [31:0] layerRGB;
  logic [7:0]  BG_RGB;
  logic        bordersDrawReq;
  logic [3:0]  enableMaskIn;
  logic        enableMaskWr;
  logic [7:0]  RGBout;
  logic        collisionPulse;
  logic [4:0]  collisionFlags;
  logic [7:0]  frameCount;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [3:0] m_pend, m_act;
  logic [4:0] m_acc, m_flags;
  logic       m_seen;
  logic [7:0] m_fc;
  logic [7:0] exp_rgb;
  logic       exp_pulse;

  layers_mux_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .layerDrawReq(layerDrawReq),
    .layerRGB(layerRGB), .BG_RGB(BG_RGB), .bordersDrawReq(bordersDrawReq),
    .enableMaskIn(enableMaskIn), .enableMaskWr(enableMaskWr),
    .RGBout(RGBout), .collisionPulse(collisionPulse),
    .collisionFlags(collisionFlags), .frameCount(frameCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pend = 4'b1111; m_act = 4'b1111;
    m_acc = 5'd0; m_flags = 5'd0; m_seen = 1'b0; m_fc = 8'd0;
    exp_rgb = 8'h00; exp_pulse = 1'b0;
  endtask

  task automatic idle();
    startOfFrame = 0; pixelX = 11'd10; pixelY = 11'd10;
    layerDrawReq = 4'b0000; layerRGB = 32'h0; BG_RGB = 8'h25;
    bordersDrawReq = 0; enableMaskIn = 4'b0000; enableMaskWr = 0;
  endtask

  // Advance one clock. The model evaluates the pixel from the rules and
  // commits its state on the edge. Outputs are sampled 1 time unit later.
  task automatic tick();
    logic [3:0] mask;
    logic       vis;
    int         winner;
    int         n;
    logic [4:0] who;
    logic [7:0] col;
    logic       coll;
    vis  = (pixelX < 640) && (pixelY < 480);
    mask = startOfFrame ? (enableMaskWr ? enableMaskIn : m_pend) : m_act;
    winner = -1; n = 0; who = 5'd0;
    for (int i = 0; i < 4; i++) begin
      if (vis && layerDrawReq[i] && mask[i] && layerRGB[8*i +: 8] != 8'hFF) begin
        if (winner < 0) winner = i;
        n++;
        who[i] = 1'b1;
      end
    end
    if (vis && bordersDrawReq) begin n++; who[4] = 1'b1; end
    if (!vis) col = 8'h00;
    else if (winner >= 0) col = layerRGB[8*winner +: 8];
    else col = BG_RGB;
    coll = (n >= 2);
    @(posedge clk);
    if (startOfFrame) begin
      m_flags = m_acc; m_acc = 5'd0; m_seen = 1'b0; m_fc = m_fc + 8'd1;
      m_act = mask;
    end
    if (enableMaskWr) m_pend = enableMaskIn;
    exp_rgb   = col;
    exp_pulse = coll && !m_seen;
    if (coll) begin m_acc = m_acc | who; m_seen = 1'b1; end
    #1;
  endtask

  task automatic sof_cycle();
    startOfFrame = 1; tick(); startOfFrame = 0;
  endtask

  task automatic test_reset();
    idle(); resetN = 0; model_reset();
    #12;
    checks++; if (RGBout !== 8'h00) begin errors++; $display("FAIL reset_rgb got=%h exp=00", RGBout); end
    checks++; if (collisionPulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got=%b exp=0", collisionPulse); end
    checks++; if (collisionFlags !== 5'd0) begin errors++; $display("FAIL reset_flags got=%b exp=0", collisionFlags); end
    checks++; if (frameCount !== 8'd0) begin errors++; $display("FAIL reset_fc got=%0d exp=0", frameCount); end
    @(negedge clk); resetN = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_priority();
    idle(); sof_cycle();
    pixelX = 100; pixelY = 100; layerDrawReq = 4'b0110;
    layerRGB = {8'h00, 8'hE0, 8'h1C, 8'h00};
    tick();
    checks++; if (RGBout !== 8'h1C) begin errors++; $display("FAIL prio_rgb got=%h exp=1c", RGBout); end
    checks++; if (collisionPulse !== 1'b1) begin errors++; $display("FAIL prio_pulse got=%b exp=1", collisionPulse); end
    tick();
    checks++; if (collisionPulse !== 1'b0) begin errors++; $display("FAIL prio_second_pulse got=%b exp=0", collisionPulse); end
    idle(); tick();
  endtask

  task automatic test_transparency_mask();
    idle(); sof_cycle();
    layerDrawReq = 4'b1001; layerRGB = {8'h03, 8'h00, 8'h00, 8'hFF};
    tick();
    checks++; if (RGBout !== 8'h03) begin errors++; $display("FAIL transp_rgb got=%h exp=03", RGBout); end
    checks++; if (collisionPulse !== 1'b0) begin errors++; $display("FAIL transp_pulse got=%b exp=0", collisionPulse); end
    enableMaskIn = 4'b0111; enableMaskWr = 1; tick(); enableMaskWr = 0;
    tick();
    checks++; if (RGBout !== 8'h03) begin errors++; $display("FAIL mask_midframe got=%h exp=03", RGBout); end
    sof_cycle();
    checks++; if (RGBout !== 8'h25) begin errors++; $display("FAIL mask_sof got=%h exp=25", RGBout); end
    tick();
    checks++; if (RGBout !== 8'h25) begin errors++; $display("FAIL mask_after got=%h exp=25", RGBout); end
    enableMaskIn = 4'b1111; enableMaskWr = 1; tick(); enableMaskWr = 0;
    idle(); sof_cycle();
  endtask

  task automatic test_blanking();
    idle(); sof_cycle();
    pixelX = 640; layerDrawReq = 4'b0011; layerRGB = 32'h0000_4411;
    tick();
    checks++; if (RGBout !== 8'h00) begin errors++; $display("FAIL blank_rgb got=%h exp=00", RGBout); end
    checks++; if (collisionPulse !== 1'b0) begin errors++; $display("FAIL blank_pulse got=%b exp=0", collisionPulse); end
    idle(); pixelY = 480; bordersDrawReq = 1; layerDrawReq = 4'b0001; layerRGB = 32'h11;
    tick();
    checks++; if (RGBout !== 8'h00) begin errors++; $display("FAIL blank_y_rgb got=%h exp=00", RGBout); end
    idle(); sof_cycle();
    checks++; if (collisionFlags !== 5'd0) begin errors++; $display("FAIL blank_flags got=%b exp=00000", collisionFlags); end
  endtask

  task automatic test_frame_flags();
    int pulses;
    logic [7:0] fc0;
    idle(); sof_cycle();
    fc0 = frameCount; pulses = 0;
    for (int k = 0; k < 3; k++) begin
      pixelX = 11'(50 + 20*k); layerDrawReq = 4'b0100; layerRGB = 32'h0044_0000;
      bordersDrawReq = 1; tick(); pulses += int'(collisionPulse);
      idle(); tick(); pulses += int'(collisionPulse);
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL flags_pulses got=%0d exp=1", pulses); end
    sof_cycle();
    checks++; if (collisionFlags !== 5'b10100) begin errors++; $display("FAIL flags_pub got=%b exp=10100", collisionFlags); end
    checks++; if (frameCount !== fc0 + 8'd1) begin errors++; $display("FAIL flags_fc got=%0d exp=%0d", frameCount, fc0 + 8'd1); end
    for (int k = 0; k < 4; k++) tick();
    checks++; if (collisionFlags !== 5'b10100) begin errors++; $display("FAIL flags_hold got=%b exp=10100", collisionFlags); end
    sof_cycle();
    checks++; if (collisionFlags !== 5'b00000) begin errors++; $display("FAIL flags_clear got=%b exp=00000", collisionFlags); end
  endtask

  task automatic test_simultaneous();
    idle(); sof_cycle();
    layerDrawReq = 4'b0011; layerRGB = 32'h0000_2010; tick();
    startOfFrame = 1; enableMaskWr = 1; enableMaskIn = 4'b0001;
    bordersDrawReq = 1; tick();
    startOfFrame = 0; enableMaskWr = 0; bordersDrawReq = 0;
    checks++; if (collisionFlags !== 5'b00011) begin errors++; $display("FAIL sim_flags got=%b exp=00011", collisionFlags); end
    checks++; if (collisionPulse !== 1'b1) begin errors++; $display("FAIL sim_pulse got=%b exp=1", collisionPulse); end
    checks++; if (RGBout !== 8'h10) begin errors++; $display("FAIL sim_rgb got=%h exp=10", RGBout); end
    layerDrawReq = 4'b0010; tick();
    checks++; if (RGBout !== 8'h25) begin errors++; $display("FAIL sim_mask got=%h exp=25", RGBout); end
    idle(); sof_cycle();
    checks++; if (collisionFlags !== 5'b10001) begin errors++; $display("FAIL sim_newframe got=%b exp=10001", collisionFlags); end
    enableMaskIn = 4'b1111; enableMaskWr = 1; tick(); enableMaskWr = 0;
    idle(); sof_cycle();
  endtask

  task automatic test_random();
    logic prev_sof;
    prev_sof = 0;
    for (int c = 0; c < 600; c++) begin
      startOfFrame   = !prev_sof && ($urandom_range(0, 29) == 0);
      pixelX         = 11'($urandom_range(0, 700));
      pixelY         = 11'($urandom_range(0, 520));
      layerDrawReq   = 4'($urandom);
      for (int i = 0; i < 4; i++)
        layerRGB[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      BG_RGB         = 8'($urandom);
      bordersDrawReq = ($urandom_range(0, 3) == 0);
      enableMaskWr   = ($urandom_range(0, 15) == 0);
      enableMaskIn   = 4'($urandom);
      prev_sof       = startOfFrame;
      tick();
      checks++; if (RGBout !== exp_rgb) begin errors++; $display("FAIL rnd_rgb c=%0d got=%h exp=%h", c, RGBout, exp_rgb); end
      checks++; if (collisionPulse !== exp_pulse) begin errors++; $display("FAIL rnd_pulse c=%0d got=%b exp=%b", c, collisionPulse, exp_pulse); end
      checks++; if (collisionFlags !== m_flags) begin errors++; $display("FAIL rnd_flags c=%0d got=%b exp=%b", c, collisionFlags, m_flags); end
      checks++; if (frameCount !== m_fc) begin errors++; $display("FAIL rnd_fc c=%0d got=%0d exp=%0d", c, frameCount, m_fc); end
    end
    idle(); enableMaskIn = 4'b1111; enableMaskWr = 1; tick(); enableMaskWr = 0;
    sof_cycle();
  endtask

  task automatic test_wrap();
    logic [7:0] fc0;
    idle(); tick();
    fc0 = frameCount;
    for (int f = 0; f < 256; f++) begin sof_cycle(); tick(); end
    checks++; if (frameCount !== fc0) begin errors++; $display("FAIL wrap_fc got=%0d exp=%0d", frameCount, fc0); end
    checks++; if (frameCount !== m_fc) begin errors++; $display("FAIL wrap_model got=%0d exp=%0d", frameCount, m_fc); end
  endtask

  task automatic test_reset_midframe();
    idle();
    enableMaskIn = 4'b0001; enableMaskWr = 1; sof_cycle(); enableMaskWr = 0;
    layerDrawReq = 4'b0011; layerRGB = 32'h0000_2010; tick();
    #2 resetN = 0; model_reset();
    #1;
    checks++; if (RGBout !== 8'h00) begin errors++; $display("FAIL rstmid_rgb got=%h exp=00", RGBout); end
    checks++; if (collisionPulse !== 1'b0) begin errors++; $display("FAIL rstmid_pulse got=%b exp=0", collisionPulse); end
    checks++; if (frameCount !== 8'd0) begin errors++; $display("FAIL rstmid_fc got=%0d exp=0", frameCount); end
    #1 resetN = 1;
    idle(); layerDrawReq = 4'b1000; layerRGB = 32'h0300_0000;
    sof_cycle();
    checks++; if (RGBout !== 8'h03) begin errors++; $display("FAIL rstmid_mask got=%h exp=03", RGBout); end
    checks++; if (collisionFlags !== 5'd0) begin errors++; $display("FAIL rstmid_flags got=%b exp=0", collisionFlags); end
    checks++; if (frameCount !== 8'd1) begin errors++; $display("FAIL rstmid_fc1 got=%0d exp=1", frameCount); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_transparency_mask();
    test_blanking();
    test_frame_flags();
    test_simultaneous();
    test_random();
    test_wrap();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
